// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            kill;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, operand1, operand2, kill,
                  input  busy, stall, done, result);
  modport slave  (input  start, op, operand1, operand2, kill,
                  output busy, stall, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: 32-step shift-add multiply / restoring divide on magnitudes,
// with sign fixup and a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  localparam logic [XLEN-1:0] ALL1 = '1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier->product low / dividend->quotient
  logic [XLEN-1:0] b_q, b_d;       // multiplicand / divisor magnitude
  logic            neg_q, neg_d;   // product or quotient negated
  logic            rneg_q, rneg_d; // remainder takes dividend sign
  logic            spec_q, spec_d; // lo_q already holds the final special-case value
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] fin_res;

  // operand decode
  logic            sgn1, sgn2, s1n, s2n, div0, ovf;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    sgn1 = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    sgn2 = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    s1n  = sgn1 & bus.operand1[XLEN-1];
    s2n  = sgn2 & bus.operand2[XLEN-1];
    mag1 = s1n ? (~bus.operand1 + 1'b1) : bus.operand1;
    mag2 = s2n ? (~bus.operand2 + 1'b1) : bus.operand2;
    div0 = bus.op[2] && (bus.operand2 == '0);
    ovf  = bus.op[2] && !bus.op[0] && (bus.operand1 == SMIN) && (bus.operand2 == ALL1);
  end

  // one iteration of each algorithm
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, lo_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh[XLEN-1:0] - b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
      done_q  <= (state_q == FINISH) && !bus.kill;
      if ((state_q == FINISH) && !bus.kill) result_q <= fin_res;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    spec_d  = spec_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.kill) begin
          op_d   = bus.op;
          acc_d  = '0;
          lo_d   = mag1;
          b_d    = mag2;
          cnt_d  = '0;
          neg_d  = s1n ^ s2n;
          rneg_d = s1n;
          spec_d = 1'b0;
          state_d = CALC;
          if (div0) begin
            spec_d  = 1'b1;
            lo_d    = bus.op[1] ? bus.operand1 : ALL1;
            state_d = FINISH;
          end else if (ovf) begin
            spec_d  = 1'b1;
            lo_d    = bus.op[1] ? '0 : SMIN;
            state_d = FINISH;
          end
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            acc_d = div_ge ? div_diff : div_sh[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], div_ge};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   quo_f, rem_f;

  always_comb begin
    prod   = {acc_q, lo_q};
    prod_f = neg_q ? (~prod + 1'b1) : prod;
    quo_f  = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_f  = rneg_q ? (~acc_q + 1'b1) : acc_q;
    case (op_q)
      3'b000:         fin_res = prod_f[XLEN-1:0];
      3'b100, 3'b101: fin_res = quo_f;
      3'b110, 3'b111: fin_res = rem_f;
      default:        fin_res = prod_f[2*XLEN-1:XLEN];
    endcase
    if (spec_q) fin_res = lo_q;
    bus.busy   = (state_q != IDLE);
    bus.stall  = (state_q != IDLE) || (bus.start && (state_q == IDLE));
    bus.done   = done_q;
    bus.result = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; lat = edges from accept to done cycle (-1 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bus.start = 1'b1; bus.op = op; bus.operand1 = a; bus.operand2 = b;
    tick();
    bus.start = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.done) begin lat = i; res = bus.result; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.operand1 = '0; bus.operand2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    n_chk++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_chk++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.result); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    tick();
  endtask

  task automatic test_vectors(input string name, input int exp_lat,
                              input logic [2:0] ops[4], input logic [31:0] as[4],
                              input logic [31:0] bs[4], input logic [31:0] exps[4]);
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat);
      n_chk++; if (r !== exps[i]) begin n_fail++; $display("FAIL %s_res[%0d] got %h exp %h", name, i, r, exps[i]); end
      n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s_lat[%0d] got %0d exp %0d", name, i, lat, exp_lat); end
      n_chk++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
        n_fail++; $display("FAIL %s_donecyc[%0d] busy %b stall %b exp 0 0", name, i, bus.busy, bus.stall); end
      tick();
    end
  endtask

  task automatic test_mul();
    test_vectors("mul", 33, '{3'b000, 3'b001, 3'b011, 3'b010},
                 '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                 '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002},
                 '{32'h0000002A, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF});
  endtask

  task automatic test_div();
    test_vectors("div", 33, '{3'b100, 3'b110, 3'b101, 3'b111},
                 '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9},
                 '{32'd2, 32'd2, 32'd2, 32'd2},
                 '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001});
  endtask

  task automatic test_special();
    test_vectors("spec", 1, '{3'b100, 3'b110, 3'b100, 3'b110},
                 '{32'd5, 32'd5, 32'h80000000, 32'h80000000},
                 '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                 '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00000000});
  endtask

  task automatic test_start_while_busy();
    int lat = -1;
    logic [31:0] r = 'x;
    bus.start = 1'b1; bus.op = 3'b000; bus.operand1 = 32'd7; bus.operand2 = 32'd6;
    tick();  // E0
    bus.start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 10) begin bus.start = 1'b1; bus.operand1 = 32'd100; bus.operand2 = 32'd100; end
      tick();
      if (i == 10) bus.start = 1'b0;
      if (i == 5) begin
        n_chk++; if (bus.busy !== 1'b1 || bus.stall !== 1'b1) begin
          n_fail++; $display("FAIL busy_mid busy %b stall %b exp 1 1", bus.busy, bus.stall); end
      end
      if (bus.done) begin lat = i; r = bus.result; break; end
    end
    n_chk++; if (r !== 32'h2A) begin n_fail++; $display("FAIL ignore_start_res got %h exp 0000002a", r); end
    n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_start_lat got %0d exp 33", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [31:0] r1 = 'x, r2 = 'x;
    bus.start = 1'b1; bus.op = 3'b000; bus.operand1 = 32'd7; bus.operand2 = 32'd6;
    tick();
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (bus.done && t1 < 0) begin
        t1 = i; r1 = bus.result;
        bus.operand1 = 32'd3; bus.operand2 = 32'd5;  // held start accepted this cycle
      end else if (t1 >= 0 && i == t1 + 1) begin
        bus.start = 1'b0;
      end else if (bus.done && t1 >= 0) begin
        t2 = i; r2 = bus.result; break;
      end
    end
    bus.start = 1'b0;
    n_chk++; if (r1 !== 32'h2A) begin n_fail++; $display("FAIL b2b_res1 got %h exp 0000002a", r1); end
    n_chk++; if (r2 !== 32'h0F) begin n_fail++; $display("FAIL b2b_res2 got %h exp 0000000f", r2); end
    n_chk++; if (t2 - t1 !== 34 || t1 < 0) begin n_fail++; $display("FAIL b2b_gap got %0d exp 34", t2 - t1); end
    tick();
  endtask

  task automatic test_kill();
    int seen = 0;
    bus.start = 1'b1; bus.op = 3'b000; bus.operand1 = 32'd9; bus.operand2 = 32'd9;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    bus.kill = 1'b1;
    tick();  // E15
    bus.kill = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b exp 0", bus.busy); end
    for (int i = 0; i < 40; i++) begin tick(); if (bus.done) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL kill_nodone got %0d pulses exp 0", seen); end
    n_chk++; if (bus.result !== 32'h0F) begin n_fail++; $display("FAIL kill_hold got %h exp 0000000f", bus.result); end
  endtask

  task automatic test_kill_start_idle();
    int seen = 0;
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'b000; bus.operand1 = 32'd2; bus.operand2 = 32'd2;
    tick();
    bus.start = 1'b0; bus.kill = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL killstart_busy got %b exp 0", bus.busy); end
    for (int i = 0; i < 40; i++) begin tick(); if (bus.done) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL killstart_nodone got %0d pulses exp 0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.start = 1'b1; bus.op = 3'b101; bus.operand1 = 32'd100; bus.operand2 = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();  // E20
    reset = 1'b0;
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++; $display("FAIL rstmid busy %b done %b result %h exp 0 0 0", bus.busy, bus.done, bus.result); end
    for (int i = 0; i < 40; i++) begin tick(); if (bus.done) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_nodone got %0d pulses exp 0", seen); end
  endtask

  task automatic test_after();
    logic [31:0] r;
    int lat;
    run_op(3'b000, 32'd3, 32'd3, r, lat);
    n_chk++; if (r !== 32'h9) begin n_fail++; $display("FAIL final_mul got %h exp 00000009", r); end
    n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL final_lat got %0d exp 33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_while_busy();
    test_back_to_back();
    test_kill();
    test_kill_start_idle();
    test_reset_mid();
    test_after();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that executes the RV32M multiply/divide group (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) for the execute stage. It takes these operations off the single-cycle ALU path. It runs a 32-iteration shift-add multiply or restoring divide on internal registers and reports completion with a one-cycle done pulse. It also drives a stall to hold the pipeline while busy. It sits beside the ALU; the ALU result mux selects this block's result when done is high.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  3  funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- operand1  in  32  rs1 value; captured on accept.
- operand2  in  32  rs2 value; captured on accept.
- kill  in  1  synchronous abort (pipeline flush).
- busy  out  1  state != IDLE (combinational from state).
- stall  out  1  busy | (start & state==IDLE); combinational.
- done  out  1  registered, one-cycle completion pulse.
- result  out  32  registered result; holds until next done or reset.

## Operation
- One clock; reset is synchronous and active-high.
- States:
  - IDLE
  - CALC (32 iterations, 5-bit counter)
  - FINISH (sign fix and select)
- IDLE:
  - On start, capture op and operands, compute operand magnitudes and signs.
  - Normal operations go to CALC with counter=0.
  - Special-case divides (below) go straight to FINISH.
  - With start low, stay in IDLE.
- CALC: one iteration per edge; after the iteration with counter=31, go to FINISH.
- FINISH:
  - result <= final value, done <= 1, state <= IDLE.
  - done is 0 on every other edge.
- Operand signedness:
  - mulh, div, rem: both operands signed.
  - mulhsu: operand1 signed, operand2 unsigned.
  - mul, mulhu, divu, remu: both unsigned (mul low word is signedness-independent).
  - Signed operands are replaced by their 32-bit magnitude; the sign is kept for fixup.
- Multiply:
  - 64-bit unsigned shift-add on the magnitudes: test the multiplier LSB, conditionally add the multiplicand into the upper half, then shift right.
  - FINISH negates the 64-bit product (two's complement) when the operand signs differ.
  - mul returns bits [31:0]; mulh, mulhsu and mulhu return [63:32].
- Divide:
  - Restoring divide, 33-bit partial remainder; each iteration shifts in one dividend bit, trial-subtracts the divisor and sets one quotient bit.
  - Signed div: quotient negated when signs differ.
  - Signed rem: remainder takes the dividend's sign.
- Special cases, decided in IDLE, no CALC:
  - operand2==0: div/divu -> 0xFFFFFFFF; rem/remu -> operand1.
  - Signed overflow, operand1==0x80000000 and operand2==0xFFFFFFFF: div -> 0x80000000; rem -> 0.
- start while busy: ignored; operands are not recaptured.
- kill:
  - In CALC or FINISH: state <= IDLE, done stays 0, result unchanged.
  - kill has priority over start in the same cycle; in IDLE, kill and start together means no accept.
- reset: state IDLE, done 0, result 0, busy 0 from the first cycle after the reset edge. Reset mid-operation discards the operation with no done pulse.

## Timing
- Accept edge E0 = first rising edge with start=1 and state==IDLE.
- Normal ops:
  - CALC iterations on E1..E32; FINISH is occupied after E32.
  - done=1 and result valid in the cycle after E33, i.e. 33 edges after accept.
  - busy=1 from after E0 through after E32.
- Special cases: FINISH after E0; done in the cycle after E1 (latency 1).
- In the done cycle, state is IDLE and busy=0. A start present in that cycle is accepted as a new operation, so back-to-back throughput is 34 cycles per normal op.
- stall is high in the request cycle and during busy, and low in the done cycle. The pipeline must drop or replace start in the done cycle.
- result changes only on the done edge.

## Test plan
- Normal multiply:
  - mul 7 x 6 -> done 33 edges after accept, result 0x0000002A.
  - mulh 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
  - mulhu same operands -> 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- Signed divide:
  - div -7 / 2 -> 0xFFFFFFFD (-3).
  - rem -7 / 2 -> 0xFFFFFFFF (-1).
  - divu 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - remu same operands -> 1.
- Special cases:
  - div 5 / 0 -> 0xFFFFFFFF.
  - rem 5 / 0 -> 5.
  - div 0x80000000 / -1 -> 0x80000000.
  - rem same operands -> 0.
  - Each with done 1 edge after accept and no CALC cycles.
- Handshake:
  - Pulse start again at E10 with different operands -> ignored; original result delivered at E33.
  - start held in the done cycle -> new op accepted; second done 34 edges after the first.
- kill at E15 -> busy low next cycle, no done pulse, result holds its previous value.
- kill and start in the same IDLE cycle -> no accept.
- reset asserted at E20 -> busy, done and result are 0 after that edge, no done pulse follows.
- A subsequent mul 3 x 3 -> 0x00000009.
